// File: rtl/kronos_wb_retire.sv
// rtl/kronos_wb_retire.sv - Kronos write-back/retire stage: data-bus access for loads/stores and register write-back.
// Optional bus-wait timeout enabled by defining KRONOS_WB_TIMEOUT_EN.
module kronos_wb_retire #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        execute_vld,
    output logic        execute_rdy,
    input  logic [31:0] result,
    input  logic [4:0]  rd,
    input  logic        wr_rd,
    input  logic        ld,
    input  logic        st,
    input  logic [1:0]  mem_size,
    input  logic        ld_uns,
    input  logic [31:0] st_data,
    output logic [31:0] data_addr,
    output logic        data_req,
    output logic        data_wr_en,
    output logic [3:0]  data_mask,
    output logic [31:0] data_wr_data,
    input  logic [31:0] data_rd_data,
    input  logic        data_ack,
    output logic        regwr_en,
    output logic [4:0]  regwr_sel,
    output logic [31:0] regwr_data,
    output logic        bus_err
);

    typedef enum logic {IDLE, MEM} state_t;

    state_t      state;
    logic [4:0]  lat_rd;
    logic        lat_wr_rd;
    logic        lat_ld;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic [1:0]  off;
    logic [3:0]  mask_next;
    logic [31:0] shifted;
    logic [31:0] ld_value;

    assign execute_rdy = (state == IDLE) && !rst;
    assign off         = result[1:0];

    always_comb begin
        mask_next = 4'b1111;
        case (mem_size)
            2'd0:    mask_next = 4'b0001 << off;
            2'd1:    mask_next = 4'b0011 << off;
            default: mask_next = 4'b1111;
        endcase
    end

    // Lanes above the accessed bytes shift in as zero before extension.
    always_comb begin
        shifted  = data_rd_data >> {lat_off, 3'b000};
        ld_value = shifted;
        case (lat_size)
            2'd0:    ld_value = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_value = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
            default: ld_value = shifted;
        endcase
    end

`ifdef KRONOS_WB_TIMEOUT_EN
    logic [31:0] wait_cnt;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            data_addr    <= '0;
            data_req     <= 1'b0;
            data_wr_en   <= 1'b0;
            data_mask    <= '0;
            data_wr_data <= '0;
            regwr_en     <= 1'b0;
            regwr_sel    <= '0;
            regwr_data   <= '0;
            lat_rd       <= '0;
            lat_wr_rd    <= 1'b0;
            lat_ld       <= 1'b0;
            lat_uns      <= 1'b0;
            lat_size     <= '0;
            lat_off      <= '0;
`ifdef KRONOS_WB_TIMEOUT_EN
            bus_err      <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            regwr_en <= 1'b0;
`ifdef KRONOS_WB_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (execute_vld) begin
                        if (ld || st) begin
                            state        <= MEM;
                            data_req     <= 1'b1;
                            data_addr    <= {result[31:2], 2'b00};
                            data_wr_en   <= st;
                            data_mask    <= mask_next;
                            data_wr_data <= st_data << {off, 3'b000};
                            lat_rd       <= rd;
                            lat_wr_rd    <= wr_rd;
                            lat_ld       <= ld;
                            lat_uns      <= ld_uns;
                            lat_size     <= mem_size;
                            lat_off      <= off;
`ifdef KRONOS_WB_TIMEOUT_EN
                            wait_cnt     <= '0;
`endif
                        end else if (wr_rd) begin
                            regwr_en   <= 1'b1;
                            regwr_sel  <= rd;
                            regwr_data <= result;
                        end
                    end
                end
                MEM: begin
                    if (data_ack) begin
                        state      <= IDLE;
                        data_req   <= 1'b0;
                        data_wr_en <= 1'b0;
                        if (lat_ld && lat_wr_rd) begin
                            regwr_en   <= 1'b1;
                            regwr_sel  <= lat_rd;
                            regwr_data <= ld_value;
                        end
                    end
`ifdef KRONOS_WB_TIMEOUT_EN
                    // A timed-out load still writes back so the hazard tracker is released.
                    else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                        state      <= IDLE;
                        data_req   <= 1'b0;
                        data_wr_en <= 1'b0;
                        bus_err    <= 1'b1;
                        if (lat_ld && lat_wr_rd) begin
                            regwr_en   <= 1'b1;
                            regwr_sel  <= lat_rd;
                            regwr_data <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_wb_retire.sv
// tb/tb_kronos_wb_retire.sv - Directed scoreboard bench for kronos_wb_retire.
module tb_kronos_wb_retire;

    logic        clk = 1'b0;
    logic        rst;
    logic        execute_vld;
    logic        execute_rdy;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wr_rd;
    logic        ld;
    logic        st;
    logic [1:0]  mem_size;
    logic        ld_uns;
    logic [31:0] st_data;
    logic [31:0] data_addr;
    logic        data_req;
    logic        data_wr_en;
    logic [3:0]  data_mask;
    logic [31:0] data_wr_data;
    logic [31:0] data_rd_data;
    logic        data_ack;
    logic        regwr_en;
    logic [4:0]  regwr_sel;
    logic [31:0] regwr_data;
    logic        bus_err;

    int passed = 0;
    int total  = 0;

    logic [36:0] exp_q[$];

    kronos_wb_retire #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .execute_vld(execute_vld), .execute_rdy(execute_rdy),
        .result(result), .rd(rd), .wr_rd(wr_rd), .ld(ld), .st(st),
        .mem_size(mem_size), .ld_uns(ld_uns), .st_data(st_data),
        .data_addr(data_addr), .data_req(data_req), .data_wr_en(data_wr_en),
        .data_mask(data_mask), .data_wr_data(data_wr_data),
        .data_rd_data(data_rd_data), .data_ack(data_ack),
        .regwr_en(regwr_en), .regwr_sel(regwr_sel), .regwr_data(regwr_data),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Every write-back pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (regwr_en === 1'b1) begin
            check("regwr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("regwr_sel", 32'(regwr_sel), 32'(e[36:32]));
                check("regwr_data", regwr_data, e[31:0]);
            end
        end
    end

    task automatic idle_inputs();
        execute_vld = 1'b0; ld = 1'b0; st = 1'b0; wr_rd = 1'b0;
        result = '0; rd = '0; mem_size = '0; ld_uns = 1'b0; st_data = '0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] res, input logic w);
        execute_vld = 1'b1; ld = 1'b0; st = 1'b0;
        rd = r; result = res; wr_rd = w;
        check("alu_rdy", 32'(execute_rdy), 32'd1);
        if (w) exp_q.push_back({r, res});
        @(negedge clk);
    endtask

    // Drives one memory op from a negedge and returns at the negedge where write-back is visible.
    task automatic mem_op(input logic is_ld, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] r, input logic w, input int waits,
                          input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic [3:0] e_mask, input logic [31:0] e_wdata,
                          input logic [31:0] e_reg);
        execute_vld = 1'b1; ld = is_ld; st = !is_ld; mem_size = sz; ld_uns = uns;
        result = addr; st_data = sdata; rd = r; wr_rd = w;
        check("mem_accept_rdy", 32'(execute_rdy), 32'd1);
        @(negedge clk);
        idle_inputs();
        check("mem_req", 32'(data_req), 32'd1);
        check("mem_rdy_busy", 32'(execute_rdy), 32'd0);
        check("mem_addr", data_addr, e_addr);
        check("mem_mask", 32'(data_mask), 32'(e_mask));
        check("mem_wr_en", 32'(data_wr_en), 32'(!is_ld));
        if (!is_ld) check("mem_wr_data", data_wr_data, e_wdata);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("wait_req", 32'(data_req), 32'd1);
            check("wait_addr", data_addr, e_addr);
            check("wait_mask", 32'(data_mask), 32'(e_mask));
            check("wait_rdy", 32'(execute_rdy), 32'd0);
        end
        data_ack = 1'b1; data_rd_data = rdata;
        if (is_ld && w) exp_q.push_back({r, e_reg});
        @(negedge clk);
        data_ack = 1'b0; data_rd_data = 32'h5A5A5A5A;
        check("done_req", 32'(data_req), 32'd0);
        check("done_rdy", 32'(execute_rdy), 32'd1);
        check("done_regwr_en", 32'(regwr_en), 32'(is_ld && w));
    endtask

    initial begin
        rst = 1'b1; data_ack = 1'b0; data_rd_data = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_rdy", 32'(execute_rdy), 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_regwr_en", 32'(regwr_en), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_mask", 32'(data_mask), 32'd0);
        check("rst_wr_data", data_wr_data, 32'd0);
        check("rst_regwr_data", regwr_data, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        alu(5'd5, 32'hDEADBEEF, 1'b1);
        check("alu_regwr_en", 32'(regwr_en), 32'd1);
        alu(5'd1, 32'h00000011, 1'b1);
        alu(5'd2, 32'h00000022, 1'b1);
        alu(5'd3, 32'h00000033, 1'b0);
        data_ack = 1'b1;
        alu(5'd4, 32'h00000044, 1'b1);
        idle_inputs();
        data_ack = 1'b0;
        @(negedge clk);
        check("alu_pulse_single", 32'(regwr_en), 32'd0);
        check("ack_idle_no_req", 32'(data_req), 32'd0);

        mem_op(1'b1, 2'd0, 1'b0, 32'h00001003, 32'h0, 5'd9, 1'b1, 0, 32'h80123456,
               32'h00001000, 4'b1000, 32'h0, 32'hFFFFFF80);
        mem_op(1'b0, 2'd1, 1'b0, 32'h00002002, 32'h1234ABCD, 5'd6, 1'b1, 0, 32'h0,
               32'h00002000, 4'b1100, 32'hABCD0000, 32'h0);
        mem_op(1'b1, 2'd2, 1'b0, 32'h00000104, 32'h0, 5'd0, 1'b1, 3, 32'hCAFEF00D,
               32'h00000104, 4'b1111, 32'h0, 32'hCAFEF00D);
        mem_op(1'b1, 2'd1, 1'b1, 32'h00003001, 32'h0, 5'd12, 1'b1, 1, 32'h11FF8822,
               32'h00003000, 4'b0110, 32'h0, 32'h0000FF88);
        mem_op(1'b1, 2'd0, 1'b0, 32'h00004001, 32'h0, 5'd13, 1'b1, 0, 32'h00007F00,
               32'h00004000, 4'b0010, 32'h0, 32'h0000007F);
        mem_op(1'b0, 2'd0, 1'b0, 32'h00005002, 32'h000000A5, 5'd14, 1'b1, 2, 32'h0,
               32'h00005000, 4'b0100, 32'h00A50000, 32'h0);

        // Reset while a load is waiting for its ack.
        execute_vld = 1'b1; ld = 1'b1; mem_size = 2'd2; result = 32'h00006000; rd = 5'd20; wr_rd = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("rstmem_req", 32'(data_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmem_req_drop", 32'(data_req), 32'd0);
        check("rstmem_regwr_en", 32'(regwr_en), 32'd0);
        check("rstmem_rdy", 32'(execute_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mem_op(1'b1, 2'd2, 1'b0, 32'h00006008, 32'h0, 5'd21, 1'b1, 1, 32'h01020304,
               32'h00006008, 4'b1111, 32'h0, 32'h01020304);

`ifdef KRONOS_WB_TIMEOUT_EN
        execute_vld = 1'b1; ld = 1'b1; mem_size = 2'd2; result = 32'h00007000; rd = 5'd7; wr_rd = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("to_wait_req", 32'(data_req), 32'd1);
            check("to_wait_err", 32'(bus_err), 32'd0);
            @(negedge clk);
        end
        check("to_last_req", 32'(data_req), 32'd1);
        exp_q.push_back({5'd7, 32'h0});
        @(negedge clk);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_req_drop", 32'(data_req), 32'd0);
        check("to_rdy", 32'(execute_rdy), 32'd1);
        @(negedge clk);
        check("to_err_pulse", 32'(bus_err), 32'd0);
`else
        check("bus_err_tied", 32'(bus_err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
